// File: rtl/hit_event_gen.sv
// hit_event_gen: turns collision-logic hit levels into per-enemy kill scores and a paced
// active-low player-hit pulse train. Optional input debounce is enabled by HIT_DEBOUNCE_EN.
module hit_event_gen #(
    parameter int PULSE_LOW  = 4,
    parameter int PULSE_GAP  = 4,
    parameter int SCORE_MAX  = 31,
    parameter int DEB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_en,
    input  logic [3:0] enytank_hit,
    input  logic       mytank_hit,
    output logic [4:0] scorea,
    output logic [4:0] scoreb,
    output logic [4:0] scorec,
    output logic [4:0] scored,
    output logic       mytank_state,
    output logic [6:0] total_score,
    output logic       bonus_pulse,
    output logic [2:0] hit_pending,
    output logic       sat_flag
);

    localparam int MAX_A = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
    localparam int MAX_B = (MAX_A > DEB_CYCLES) ? MAX_A : DEB_CYCLES;
    localparam int CW    = (MAX_B < 2) ? 1 : $clog2(MAX_B + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [4:0]    raw_s;
    logic [4:0]    ev_s;
    logic [4:0]    score_r [4];
    logic [4:0]    score_next_s [4];
    logic          score_clamp_s;
    logic [6:0]    total_r;
    logic [6:0]    sum_s;
    logic          bonus_r;
    logic          bonus_s;
    logic [2:0]    pend_r;
    logic [2:0]    pend_next_s;
    logic          queue_clamp_s;
    logic          take_s;
    logic          sat_r;
    logic          mytank_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;

    assign raw_s = {mytank_hit, enytank_hit};

`ifdef HIT_DEBOUNCE_EN
    logic [4:0]    sync1_r;
    logic [4:0]    sync2_r;
    logic [4:0]    deb_ev_r;
    logic [CW-1:0] deb_cnt_r [5];

    // Synchronise each input and emit one event after DEB_CYCLES stable-high cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r  <= 5'd0;
            sync2_r  <= 5'd0;
            deb_ev_r <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= {CW{1'b0}};
            end
        end else if (!game_en) begin
            // Preload as already-counted so a level held across the clear never fires.
            sync1_r  <= raw_s;
            sync2_r  <= raw_s;
            deb_ev_r <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= raw_s[i] ? CW'(DEB_CYCLES) : {CW{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 5; i++) begin
                deb_ev_r[i] <= sync2_r[i] && (deb_cnt_r[i] == CW'(DEB_CYCLES - 1));
                if (!sync2_r[i]) begin
                    deb_cnt_r[i] <= {CW{1'b0}};
                end else if (deb_cnt_r[i] != CW'(DEB_CYCLES)) begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i];
                end
            end
        end
    end

    assign ev_s = deb_ev_r;
`else
    logic [4:0] prev_r;

    // Edge history; a clear reloads it with the live inputs to swallow held levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r <= 5'd0;
        end else begin
            prev_r <= raw_s;
        end
    end

    assign ev_s = raw_s & ~prev_r;
`endif

    // Next score per enemy, saturating at SCORE_MAX.
    always_comb begin
        score_clamp_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_next_s[i] = score_r[i];
            if (ev_s[i]) begin
                if (score_r[i] == 5'(SCORE_MAX)) begin
                    score_clamp_s = 1'b1;
                end else begin
                    score_next_s[i] = score_r[i] + 5'd1;
                end
            end else begin
                score_next_s[i] = score_r[i];
            end
        end
        sum_s   = 7'(score_r[0]) + 7'(score_r[1]) + 7'(score_r[2]) + 7'(score_r[3]);
        bonus_s = (sum_s != total_r) &&
                  ((sum_s == 7'd10) || (sum_s == 7'd20) || (sum_s == 7'd30));
    end

    // A pulse may start from IDLE, or straight out of an expiring GAP.
    always_comb begin
        case (state_r)
            ST_IDLE: take_s = (pend_r != 3'd0) || ev_s[4];
            ST_GAP:  take_s = (cnt_r == {CW{1'b0}}) && ((pend_r != 3'd0) || ev_s[4]);
            ST_LOW:  take_s = 1'b0;
            default: take_s = 1'b0;
        endcase
    end

    // Hit queue: a new edge and a started pulse in the same cycle cancel out.
    always_comb begin
        pend_next_s   = pend_r;
        queue_clamp_s = 1'b0;
        if (ev_s[4] && !take_s) begin
            if (pend_r == 3'd7) begin
                queue_clamp_s = 1'b1;
            end else begin
                pend_next_s = pend_r + 3'd1;
            end
        end else if (!ev_s[4] && take_s) begin
            pend_next_s = pend_r - 3'd1;
        end else begin
            pend_next_s = pend_r;
        end
    end

    // Score, total, bonus and sticky saturation registers.
    always_ff @(posedge clk) begin
        if (!rst_n || !game_en) begin
            for (int i = 0; i < 4; i++) begin
                score_r[i] <= 5'd0;
            end
            total_r <= 7'd0;
            bonus_r <= 1'b0;
            sat_r   <= 1'b0;
            pend_r  <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                score_r[i] <= score_next_s[i];
            end
            total_r <= sum_s;
            bonus_r <= bonus_s;
            sat_r   <= sat_r | score_clamp_s | queue_clamp_s;
            pend_r  <= pend_next_s;
        end
    end

    // Player pulse FSM; a started pulse always runs its full low and gap time.
    always_ff @(posedge clk) begin
        if (!rst_n || !game_en) begin
            state_r  <= ST_IDLE;
            mytank_r <= 1'b1;
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        state_r  <= ST_LOW;
                        mytank_r <= 1'b0;
                        cnt_r    <= CW'(PULSE_LOW - 1);
                    end else begin
                        state_r  <= ST_IDLE;
                        mytank_r <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                ST_LOW: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r  <= ST_GAP;
                        mytank_r <= 1'b1;
                        cnt_r    <= CW'(PULSE_GAP - 1);
                    end else begin
                        mytank_r <= 1'b0;
                        cnt_r    <= cnt_r - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        mytank_r <= 1'b1;
                        cnt_r    <= cnt_r - CW'(1);
                    end else if (take_s) begin
                        state_r  <= ST_LOW;
                        mytank_r <= 1'b0;
                        cnt_r    <= CW'(PULSE_LOW - 1);
                    end else begin
                        state_r  <= ST_IDLE;
                        mytank_r <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mytank_r <= 1'b1;
                    cnt_r    <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign scorea       = score_r[0];
    assign scoreb       = score_r[1];
    assign scorec       = score_r[2];
    assign scored       = score_r[3];
    assign total_score  = total_r;
    assign bonus_pulse  = bonus_r;
    assign hit_pending  = pend_r;
    assign sat_flag     = sat_r;
    assign mytank_state = mytank_r;

endmodule

// File: tb/tb_hit_event_gen.sv
// Bench for hit_event_gen: directed stimulus, a per-cycle schedule-based reference model,
// and hand-computed literal checks at key points.
module tb_hit_event_gen;

    localparam int PL   = 4;
    localparam int PG   = 4;
    localparam int SMAX = 31;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_en;
    logic [3:0] enytank_hit;
    logic       mytank_hit;
    logic [4:0] scorea, scoreb, scorec, scored;
    logic       mytank_state;
    logic [6:0] total_score;
    logic       bonus_pulse;
    logic [2:0] hit_pending;
    logic       sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hit_event_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_en      (game_en),
        .enytank_hit  (enytank_hit),
        .mytank_hit   (mytank_hit),
        .scorea       (scorea),
        .scoreb       (scoreb),
        .scorec       (scorec),
        .scored       (scored),
        .mytank_state (mytank_state),
        .total_score  (total_score),
        .bonus_pulse  (bonus_pulse),
        .hit_pending  (hit_pending),
        .sat_flag     (sat_flag)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted player hit gets a scheduled low-pulse start time.
    int         m_score [4];
    int         m_total;
    bit         m_bonus;
    bit         m_sat;
    logic [4:0] m_prev;
    int         starts[$];
    int         last_start;
    int         cyc;
    bit         started;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        m_total    = 0;
        m_bonus    = 0;
        m_sat      = 0;
        starts.delete();
        last_start = -100;
    endtask

    initial begin
        cyc     = 0;
        started = 0;
        m_prev  = 5'd0;
        model_clear();
    end

    always begin : model_p
        logic       s_rst;
        logic       s_en;
        logic [4:0] s_in;
        logic [4:0] ev;
        int         nt;
        int         q;
        int         st;
        int         pend;
        int         low;
        @(posedge clk);
        s_rst = rst_n;
        s_en  = game_en;
        s_in  = {mytank_hit, enytank_hit};
        #1;
        cyc++;
        if (!s_rst) begin
            model_clear();
            m_prev  = 5'd0;
            started = 1;
        end else if (!s_en) begin
            model_clear();
            m_prev = s_in;
        end else begin
            ev     = s_in & ~m_prev;
            m_prev = s_in;
            nt = m_score[0] + m_score[1] + m_score[2] + m_score[3];
            m_bonus = (nt != m_total) && (nt == 10 || nt == 20 || nt == 30);
            m_total = nt;
            for (int i = 0; i < 4; i++) begin
                if (ev[i]) begin
                    if (m_score[i] == SMAX) m_sat = 1;
                    else m_score[i]++;
                end
            end
            if (ev[4]) begin
                q = 0;
                foreach (starts[i]) if (starts[i] > cyc) q++;
                if (q == 7) begin
                    m_sat = 1;
                end else begin
                    st = (cyc > last_start + PL + PG) ? cyc : last_start + PL + PG;
                    starts.push_back(st);
                    last_start = st;
                end
            end
        end
        while (starts.size() > 0 && starts[0] + PL <= cyc - 1) void'(starts.pop_front());
        pend = 0;
        low  = 0;
        foreach (starts[i]) begin
            if (starts[i] > cyc) pend++;
            if (starts[i] <= cyc && cyc < starts[i] + PL) low = 1;
        end
        if (started) begin
            chk("scorea", scorea, m_score[0]);
            chk("scoreb", scoreb, m_score[1]);
            chk("scorec", scorec, m_score[2]);
            chk("scored", scored, m_score[3]);
            chk("total_score", total_score, m_total);
            chk("bonus_pulse", bonus_pulse, m_bonus);
            chk("sat_flag", sat_flag, m_sat);
            chk("hit_pending", hit_pending, pend);
            chk("mytank_state", mytank_state, low ? 0 : 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lows, falls, maxp, p3, p5;
    logic prev_ms;

    initial begin
        rst_n       = 1'b0;
        game_en     = 1'b0;
        enytank_hit = 4'b0000;
        mytank_hit  = 1'b0;
        tick(3);
        rst_n   = 1'b1;
        game_en = 1'b1;
        tick(50);
        chk("idle_scorea", scorea, 0);
        chk("idle_mytank", mytank_state, 1);
        chk("idle_pending", hit_pending, 0);

        // Two enemies destroyed together.
        enytank_hit = 4'b0101;
        tick(3);
        enytank_hit = 4'b0000;
        tick(1);
        chk("pair_scorea", scorea, 1);
        chk("pair_scorec", scorec, 1);
        chk("pair_scoreb", scoreb, 0);
        chk("pair_scored", scored, 0);
        chk("pair_total", total_score, 2);

        // Saturate scoreb.
        for (int i = 0; i < 31; i++) begin
            enytank_hit[1] = 1'b1; tick(1);
            enytank_hit[1] = 1'b0; tick(1);
        end
        chk("sat_scoreb31", scoreb, 31);
        chk("sat_flag_before", sat_flag, 0);
        enytank_hit[1] = 1'b1; tick(1);
        enytank_hit[1] = 1'b0; tick(1);
        chk("sat_scoreb_hold", scoreb, 31);
        chk("sat_flag_after", sat_flag, 1);

        // Round clear, then walk total 9 -> 10 -> 11 through scored.
        game_en = 1'b0; tick(1);
        game_en = 1'b1; tick(1);
        chk("clear_total", total_score, 0);
        for (int i = 0; i < 9; i++) begin
            enytank_hit[3] = 1'b1; tick(1);
            enytank_hit[3] = 1'b0; tick(1);
        end
        chk("bonus_total9", total_score, 9);
        enytank_hit[3] = 1'b1; tick(1);
        chk("bonus_scored10", scored, 10);
        chk("bonus_pre", bonus_pulse, 0);
        enytank_hit[3] = 1'b0; tick(1);
        chk("bonus_total10", total_score, 10);
        chk("bonus_fire", bonus_pulse, 1);
        tick(1);
        chk("bonus_once", bonus_pulse, 0);
        enytank_hit[3] = 1'b1; tick(1);
        enytank_hit[3] = 1'b0; tick(1);
        chk("bonus_total11", total_score, 11);
        chk("bonus_none11", bonus_pulse, 0);

        // Three player hits two cycles apart.
        lows = 0; falls = 0; maxp = 0; p3 = -1; p5 = -1; prev_ms = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if (mytank_state == 1'b0) lows++;
            if (prev_ms && !mytank_state) falls++;
            prev_ms = mytank_state;
            if (int'(hit_pending) > maxp) maxp = hit_pending;
            if (j == 3) p3 = hit_pending;
            if (j == 5) p5 = hit_pending;
            mytank_hit = (j == 0 || j == 2 || j == 4);
            tick(1);
        end
        chk("hits_low_cycles", lows, 3 * PL);
        chk("hits_falls", falls, 3);
        chk("hits_pend_1", p3, 1);
        chk("hits_pend_2", p5, 2);
        chk("hits_pend_max", maxp, 2);
        chk("hits_pend_drain", hit_pending, 0);

        // Abort a pulse with the queue at 2, inputs held high across the clear.
        for (int j = 0; j < 9; j++) begin
            mytank_hit     = (j == 0 || j == 2 || j == 4 || j >= 6);
            enytank_hit[0] = (j >= 6);
            tick(1);
        end
        chk("abort_pre_low", mytank_state, 0);
        chk("abort_pre_pend", hit_pending, 2);
        game_en = 1'b0; tick(1);
        chk("abort_mytank", mytank_state, 1);
        chk("abort_pend", hit_pending, 0);
        chk("abort_scorea", scorea, 0);
        chk("abort_total", total_score, 0);
        game_en = 1'b1; tick(20);
        chk("reen_scorea", scorea, 0);
        chk("reen_pend", hit_pending, 0);
        chk("reen_mytank", mytank_state, 1);
        mytank_hit  = 1'b0;
        enytank_hit = 4'b0000;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
